// File: rtl/image_buffer_readback_if.sv
`timescale 1ns/1ps
// SRAM arbiter read port (R1): credit-limited address issue plus always-accepted data return.
interface image_buffer_readback_if;
    logic [17:0] addr;
    logic        addr_valid;
    logic        addr_ready;
    logic [31:0] data;
    logic        data_valid;
    logic        data_ready;

    modport master (
        output addr, addr_valid, data_ready,
        input  addr_ready, data, data_valid
    );

    modport slave (
        input  addr, addr_valid, data_ready,
        output addr_ready, data, data_valid
    );
endinterface

// File: rtl/image_buffer_readback.sv
`timescale 1ns/1ps
// Streams one frame back from SRAM, tallying checksum, max pixel and word count; READBACK_COMPARE_EN adds a checksum comparator.
// Stats land 1 cycle after each data beat; addresses stall on addr_ready or MAX_OUTSTANDING credits, data is never backpressured.
module image_buffer_readback #(
    parameter int          N_PIXEL         = 480000,
    parameter logic [17:0] BASE_ADDR       = 18'd0,
    parameter int          MAX_OUTSTANDING = 4
) (
    input  logic                           clk_10M,
    input  logic                           reset,
    input  logic                           start,
    output logic                           start_ack,
    output logic                           done,
    input  logic                           done_ack,
    image_buffer_readback_if.master        sram,
    output logic [31:0]                    checksum,
    output logic [7:0]                     pixel_max,
    output logic [17:0]                    words_read,
    output logic                           busy
`ifdef READBACK_COMPARE_EN
    ,
    input  logic [31:0]                    expected_checksum,
    output logic                           mismatch
`endif
);
    localparam logic [17:0] WORDS = 18'(N_PIXEL / 4);
    localparam logic [3:0]  MAXO  = 4'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, RUN, DONE, DONE_WAIT} state_t;
    state_t state, state_nxt;

    logic        start_rise;
    logic        a_fire;
    logic        d_fire;
    logic        last_word;
    logic [17:0] addr_q;
    logic [17:0] issued;
    logic [3:0]  outstanding;
    logic [9:0]  word_sum;
    logic [7:0]  word_max;
    logic [31:0] checksum_nxt;

    // start_ack doubles as the previous-cycle copy of start for edge detection
    assign start_rise      = start & ~start_ack;
    assign sram.addr       = addr_q;
    assign sram.addr_valid = (state == RUN) && (issued < WORDS) && (outstanding < MAXO);
    assign sram.data_ready = 1'b1;
    assign a_fire          = sram.addr_valid & sram.addr_ready;
    // a beat with no credit outstanding cannot belong to this run
    assign d_fire          = (state == RUN) && sram.data_valid && (outstanding != 4'd0);
    assign last_word       = d_fire && (words_read == WORDS - 18'd1);

    always_comb begin
        word_sum = '0;
        word_max = pixel_max;
        for (int k = 0; k < 4; k++) begin
            word_sum = word_sum + {2'b00, sram.data[8*k +: 8]};
            if (sram.data[8*k +: 8] > word_max)
                word_max = sram.data[8*k +: 8];
        end
    end

    assign checksum_nxt = checksum + {22'd0, word_sum};

    always_ff @(posedge clk_10M) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE:      if (start_rise) state_nxt = RUN;
            RUN: begin
                busy = 1'b1;
                if (last_word) state_nxt = DONE;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
                if (done_ack) state_nxt = DONE_WAIT;
            end
            DONE_WAIT: if (!done_ack) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_10M) begin
        if (reset) begin
            start_ack   <= 1'b0;
            addr_q      <= '0;
            issued      <= '0;
            outstanding <= '0;
            checksum    <= '0;
            pixel_max   <= '0;
            words_read  <= '0;
        end else begin
            start_ack <= start;
            if (state == IDLE && start_rise) begin
                addr_q      <= BASE_ADDR;
                issued      <= '0;
                outstanding <= '0;
                checksum    <= '0;
                pixel_max   <= '0;
                words_read  <= '0;
            end else begin
                if (a_fire) begin
                    addr_q <= addr_q + 18'd1;
                    issued <= issued + 18'd1;
                end
                if (a_fire && !d_fire)
                    outstanding <= outstanding + 4'd1;
                else if (!a_fire && d_fire)
                    outstanding <= outstanding - 4'd1;
                if (d_fire) begin
                    checksum   <= checksum_nxt;
                    pixel_max  <= word_max;
                    words_read <= words_read + 18'd1;
                end
            end
        end
    end

`ifdef READBACK_COMPARE_EN
    logic [31:0] expected_q;

    always_ff @(posedge clk_10M) begin
        if (reset) begin
            expected_q <= '0;
            mismatch   <= 1'b0;
        end else if (state == IDLE && start_rise) begin
            expected_q <= expected_checksum;
            mismatch   <= 1'b0;
        end else if (last_word) begin
            mismatch <= (checksum_nxt != expected_q);
        end
    end
`endif

endmodule

// File: tb/tb_image_buffer_readback.sv
`timescale 1ns/1ps
// Randomized bench: SRAM responder with variable latency and addr_ready patterns, checked against a per-frame arithmetic model.
module tb_image_buffer_readback;
    localparam int          N_PIXEL = 16;
    localparam int          WORDS   = N_PIXEL / 4;
    localparam logic [17:0] BASE    = 18'h100;
    localparam int          MAXO    = 2;

    logic        clk_10M = 1'b0;
    logic        reset   = 1'b1;
    logic        start   = 1'b0;
    logic        done_ack = 1'b0;
    logic        start_ack, done, busy;
    logic [31:0] checksum;
    logic [7:0]  pixel_max;
    logic [17:0] words_read;
`ifdef READBACK_COMPARE_EN
    logic [31:0] expected_checksum = '0;
    logic        mismatch;
`endif

    image_buffer_readback_if bus();

    image_buffer_readback #(
        .N_PIXEL(N_PIXEL), .BASE_ADDR(BASE), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk_10M(clk_10M), .reset(reset), .start(start), .start_ack(start_ack),
        .done(done), .done_ack(done_ack), .sram(bus),
        .checksum(checksum), .pixel_max(pixel_max), .words_read(words_read), .busy(busy)
`ifdef READBACK_COMPARE_EN
        , .expected_checksum(expected_checksum), .mismatch(mismatch)
`endif
    );

    always #50 clk_10M = ~clk_10M;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    // SRAM contents and responder state
    logic [31:0] mem [WORDS];
    typedef struct { logic [17:0] a; int due; } rd_t;
    rd_t         pend [$];
    logic [17:0] addr_log [$];
    bit          sram_en = 1'b1;
    int          rdy_mode = 0, lat_min = 1, lat_max = 1;
    int          cyc = 0, out_cnt = 0, out_peak = 0, stall_err = 0, ack_err = 0;

    function automatic logic [31:0] word_at(input logic [17:0] a);
        logic [17:0] idx;
        idx = a - BASE;
        if (idx < 18'(WORDS)) return mem[idx];
        return 32'h0;
    endfunction

    initial begin
        bit          prev_stall;
        logic [17:0] prev_addr;
        int          a_fire, d_fire;
        rd_t         r;
        prev_stall = 1'b0;
        prev_addr  = '0;
        bus.addr_ready = 1'b0;
        bus.data_valid = 1'b0;
        bus.data       = '0;
        forever begin
            @(negedge clk_10M);
            if (reset) begin
                pend.delete();
                out_cnt    = 0;
                prev_stall = 1'b0;
            end else if (sram_en) begin
                a_fire = (bus.addr_valid && bus.addr_ready) ? 1 : 0;
                d_fire = (bus.data_valid && bus.data_ready) ? 1 : 0;
                if (prev_stall && (!bus.addr_valid || bus.addr != prev_addr)) stall_err++;
                prev_stall = bus.addr_valid && !bus.addr_ready;
                prev_addr  = bus.addr;
                if (a_fire == 1) begin
                    r.a   = bus.addr;
                    r.due = cyc + int'($urandom_range(lat_max, lat_min));
                    pend.push_back(r);
                    addr_log.push_back(bus.addr);
                end
                out_cnt = out_cnt + a_fire - d_fire;
                if (out_cnt > out_peak) out_peak = out_cnt;
            end
            @(posedge clk_10M);
            #1;
            cyc++;
            if (sram_en) begin
                case (rdy_mode)
                    0:       bus.addr_ready = 1'b1;
                    1:       bus.addr_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                    default: bus.addr_ready = 1'($urandom_range(1, 0));
                endcase
                if (pend.size() > 0 && pend[0].due <= cyc) begin
                    bus.data       = word_at(pend[0].a);
                    bus.data_valid = 1'b1;
                    void'(pend.pop_front());
                end else begin
                    bus.data_valid = 1'b0;
                    bus.data       = $urandom;
                end
            end
        end
    end

    // start_ack must be start delayed by one edge, forced low by reset
    initial begin
        logic prev_start, prev_rst, exp_ack;
        prev_start = 1'b0;
        prev_rst   = 1'b1;
        forever begin
            @(negedge clk_10M);
            exp_ack = prev_rst ? 1'b0 : prev_start;
            if (start_ack !== exp_ack) ack_err++;
            prev_start = start;
            prev_rst   = reset;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_10M);
            #2;
        end
    endtask

    task automatic check_reset_state(input string pfx);
        check_eq({pfx, "_start_ack"},  start_ack,      0);
        check_eq({pfx, "_done"},       done,           0);
        check_eq({pfx, "_busy"},       busy,           0);
        check_eq({pfx, "_addr_valid"}, bus.addr_valid, 0);
        check_eq({pfx, "_addr"},       bus.addr,       0);
        check_eq({pfx, "_checksum"},   checksum,       0);
        check_eq({pfx, "_pixel_max"},  pixel_max,      0);
        check_eq({pfx, "_words_read"}, words_read,     0);
        check_eq({pfx, "_data_ready"}, bus.data_ready, 1);
`ifdef READBACK_COMPARE_EN
        check_eq({pfx, "_mismatch"},   mismatch,       0);
`endif
    endtask

    task automatic load_pattern(input int pat, output int exp_sum, output int exp_max);
        logic [7:0] b;
        exp_sum = 0;
        exp_max = 0;
        for (int i = 0; i < WORDS; i++) begin
            b = 8'(i);
            case (pat)
                0:       mem[i] = {4{b}};
                1:       mem[i] = 32'hFFFF_FFFF;
                default: mem[i] = $urandom;
            endcase
            for (int k = 0; k < 4; k++) begin
                b = mem[i][8*k +: 8];
                exp_sum += int'(b);
                if (int'(b) > exp_max) exp_max = int'(b);
            end
        end
    endtask

    task automatic hard_reset();
        @(posedge clk_10M); #2;
        reset = 1'b1; start = 1'b0; done_ack = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(16);
    endtask

    task automatic run_frame(input string nm, input int pat, input int rmode,
                             input int lmin, input int lmax, input bit bad_exp);
        int exp_sum, exp_max;
        bit got;
        load_pattern(pat, exp_sum, exp_max);
        rdy_mode = rmode; lat_min = lmin; lat_max = lmax;
        addr_log.delete();
        out_peak = 0; stall_err = 0;
`ifdef READBACK_COMPARE_EN
        expected_checksum = 32'(exp_sum) + (bad_exp ? 32'd1 : 32'd0);
`endif
        start = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 400 && !got; c++) begin
            @(negedge clk_10M);
            if (done) got = 1'b1;
        end
        check_eq({nm, "_done_seen"}, got, 1);
        if (!got) begin
            hard_reset();
            return;
        end
        check_eq({nm, "_checksum"},   checksum,   32'(exp_sum));
        check_eq({nm, "_pixel_max"},  pixel_max,  32'(exp_max));
        check_eq({nm, "_words_read"}, words_read, WORDS);
        check_eq({nm, "_busy_done"},  busy,       1);
        check_eq({nm, "_addr_count"}, addr_log.size(), WORDS);
        for (int i = 0; i < addr_log.size() && i < WORDS; i++)
            check_eq($sformatf("%s_addr%0d", nm, i), addr_log[i], 32'(BASE) + 32'(i));
        check_eq({nm, "_outstanding_le_max"}, (out_peak <= MAXO) ? 1 : 0, 1);
        check_eq({nm, "_addr_stable_stall"}, stall_err, 0);
`ifdef READBACK_COMPARE_EN
        check_eq({nm, "_mismatch"}, mismatch, bad_exp ? 1 : 0);
`endif
        tick(3);
        @(negedge clk_10M);
        check_eq({nm, "_done_hold"}, done, 1);
        @(posedge clk_10M); #2;
        done_ack = 1'b1;
        @(negedge clk_10M);
        @(negedge clk_10M);
        check_eq({nm, "_done_drop"}, done, 0);
        check_eq({nm, "_busy_wait"}, busy, 0);
        tick(4);
        done_ack = 1'b0;
        tick(5);
        @(negedge clk_10M);
        check_eq({nm, "_no_rerun"},     busy,       0);
        check_eq({nm, "_stats_frozen"}, words_read, WORDS);
        check_eq({nm, "_sum_frozen"},   checksum,   32'(exp_sum));
        @(posedge clk_10M); #2;
        start = 1'b0;
        @(negedge clk_10M);
        check_eq({nm, "_ack_hold"}, start_ack, 1);
        @(negedge clk_10M);
        check_eq({nm, "_ack_fall"}, start_ack, 0);
        tick(2);
    endtask

    task automatic mid_reset();
        int exp_sum, exp_max;
        bit got;
        load_pattern(0, exp_sum, exp_max);
        rdy_mode = 0; lat_min = 3; lat_max = 3;
        start = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 400 && !got; c++) begin
            @(negedge clk_10M);
            if (words_read >= 18'd2) got = 1'b1;
        end
        check_eq("mid_two_words", got, 1);
        @(posedge clk_10M); #2;
        reset = 1'b1;
        @(posedge clk_10M); #2;
        reset = 1'b0;
        start = 1'b0;
        sram_en = 1'b0;
        @(negedge clk_10M);
        check_reset_state("mid_rst");
        repeat (3) begin
            @(posedge clk_10M); #2;
            bus.data       = $urandom;
            bus.data_valid = 1'b1;
        end
        @(posedge clk_10M); #2;
        bus.data_valid = 1'b0;
        @(negedge clk_10M);
        check_eq("stale_checksum",   checksum,   0);
        check_eq("stale_pixel_max",  pixel_max,  0);
        check_eq("stale_words_read", words_read, 0);
        check_eq("stale_busy",       busy,       0);
        sram_en = 1'b1;
        tick(16);
        run_frame("after_rst", 0, 0, 2, 2, 1'b0);
    endtask

    initial begin
        #(100 * 30000);
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        tick(3);
        reset = 1'b0;
        @(negedge clk_10M);
        check_reset_state("reset");
        tick(16);
        run_frame("basic",    0, 0, 2, 2, 1'b0);
        run_frame("saturate", 1, 0, 1, 1, 1'b0);
        run_frame("backpres", 0, 1, 7, 7, 1'b1);
        for (int r = 0; r < 4; r++)
            run_frame($sformatf("rand%0d", r), 2, 2, 1, 8, 1'($urandom_range(1, 0)));
        mid_reset();
        check_eq("start_ack_tracks_start", ack_err, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
